// File: rtl/mra_arb_pkg.sv
// Shared configuration, types and round-robin helper for the MRA port arbiter.
package mra_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned NUM_REQ    = 3;   // 0 = tc_fsm, 1 = PF, 2 = SIMD
  localparam int unsigned MAX_OUTST  = 8;   // tag FIFO depth, power of 2
  localparam int unsigned REQ_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W      = $clog2(MAX_OUTST) + 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  typedef logic [NUM_REQ-1:0]   req_vec_t;

  // First set index at or after ptr, wrapping; returns ptr when nothing is set.
  function automatic req_idx_t rr_pick(input req_vec_t valid, input req_idx_t ptr);
    req_idx_t    res;
    req_idx_t    cand;
    logic        found;
    int unsigned idx;
    res   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % NUM_REQ;
      cand = req_idx_t'(idx);
      if (!found && valid[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mra_port_arbiter_if.sv
// Requester and MRA-side bundle for the MRA port arbiter.
interface mra_port_arbiter_if;
  import mra_arb_pkg::*;

  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  req_vec_t                      req_rw;
  req_vec_t                      req_valid;
  req_vec_t                      req_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  req_vec_t                      rsp_valid;
  logic [ADDR_WIDTH-1:0]         MRA_req_addr;
  logic                          MRA_rw;
  logic                          MRA_req_valid;
  logic                          MRA_ready;
  logic [DATA_WIDTH-1:0]         MRA_rsp_data;
  logic                          MRA_rsp_valid;
  logic [CNT_W-1:0]              outst_cnt;
  logic                          err_unexp_rsp;

  // master: requesters plus MRA; slave: the arbiter itself
  modport master (
    output req_addr, req_rw, req_valid, MRA_ready, MRA_rsp_data, MRA_rsp_valid,
    input  req_ready, rsp_data, rsp_valid, MRA_req_addr, MRA_rw, MRA_req_valid,
           outst_cnt, err_unexp_rsp
  );

  modport slave (
    input  req_addr, req_rw, req_valid, MRA_ready, MRA_rsp_data, MRA_rsp_valid,
    output req_ready, rsp_data, rsp_valid, MRA_req_addr, MRA_rw, MRA_req_valid,
           outst_cnt, err_unexp_rsp
  );

endinterface

// File: rtl/mra_tag_fifo.sv
// In-order FIFO of requester indices for reads in flight to the MRA.
module mra_tag_fifo
  import mra_arb_pkg::*;
#(
  parameter int unsigned Depth = MAX_OUTST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_idx_t                 push_idx,
  input  logic                     pop,
  output req_idx_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  req_idx_t        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (PtrW+1)'(Depth));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_idx;
  end

endmodule

// File: rtl/mra_port_arbiter.sv
// Round-robin arbiter sharing the MRA port, with stall lock and in-order response steering.
module mra_port_arbiter
  import mra_arb_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mra_port_arbiter_if.slave bus
);

  req_idx_t              rr_ptr_q, rr_ptr_d;
  req_idx_t              lock_idx_q, lock_idx_d;
  logic                  lock_q, lock_d;
  req_idx_t              grant;
  req_vec_t              elig;
  req_vec_t              ready;
  logic                  mra_valid, transfer, grant_rw;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_idx_t              fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  req_vec_t              rsp_valid_q, rsp_valid_d;
  logic                  err_q;

  always_comb begin
    // Gating with rst_n keeps the combinational outputs at 0 while reset is held.
    elig       = bus.req_valid & (bus.req_rw | {NUM_REQ{!fifo_full}}) & {NUM_REQ{rst_n}};
    grant      = lock_q ? lock_idx_q : rr_pick(elig, rr_ptr_q);
    mra_valid  = lock_q || (|elig);
    grant_addr = '0;
    grant_rw   = 1'b0;
    ready      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (mra_valid && grant == req_idx_t'(i)) begin
        grant_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_rw   = bus.req_rw[i];
        ready[i]   = bus.MRA_ready;
      end
    end
    transfer   = mra_valid && bus.MRA_ready;
    fifo_push  = transfer && !grant_rw;
    fifo_pop   = bus.MRA_rsp_valid && !fifo_empty;

    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (transfer) begin
      rr_ptr_d = (grant == req_idx_t'(NUM_REQ-1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (mra_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
    rsp_valid_d = fifo_pop ? (req_vec_t'(1) << fifo_head) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      rsp_data_q  <= bus.MRA_rsp_data;
      rsp_valid_q <= rsp_valid_d;
      if (bus.MRA_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  mra_tag_fifo #(
    .Depth (MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_idx (grant),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.req_ready     = ready;
  assign bus.MRA_req_valid = mra_valid;
  assign bus.MRA_req_addr  = grant_addr;
  assign bus.MRA_rw        = grant_rw;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.outst_cnt     = fifo_count;
  assign bus.err_unexp_rsp = err_q;

endmodule

// File: tb/tb_mra_port_arbiter.sv
// Randomized and directed bench for mra_port_arbiter against a queue-based reference model.
module tb_mra_port_arbiter;
  import mra_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mra_port_arbiter_if bus ();

  mra_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pend   = 0;

  // Reference model state
  int                    m_ptr;
  bit                    m_lock;
  int                    m_lock_idx;
  int                    tags[$];
  req_vec_t              m_rsp_valid;
  logic [DATA_WIDTH-1:0] m_rsp_data;
  logic                  m_err;

  task automatic check(input string name, input bit ok, input string act, input string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] rand_data();
    logic [DATA_WIDTH-1:0] d;
    for (int w = 0; w < int'(DATA_WIDTH / 32); w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_lock      = 1'b0;
    m_lock_idx  = 0;
    tags.delete();
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    m_err       = 1'b0;
  endtask

  task automatic model_step();
    bit                    full;
    req_vec_t              el;
    int                    g;
    logic                  e_valid;
    logic [ADDR_WIDTH-1:0] e_addr;
    logic                  e_rw;
    req_vec_t              e_ready;
    logic [CNT_W-1:0]      e_cnt;
    full = (tags.size() == int'(MAX_OUTST));
    for (int i = 0; i < int'(NUM_REQ); i++) el[i] = bus.req_valid[i] && (bus.req_rw[i] || !full);
    g = -1;
    if (m_lock) g = m_lock_idx;
    else
      for (int k = 0; k < int'(NUM_REQ); k++)
        if (g < 0 && el[(m_ptr + k) % int'(NUM_REQ)]) g = (m_ptr + k) % int'(NUM_REQ);
    e_valid = (g >= 0);
    e_addr  = e_valid ? bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    e_rw    = e_valid ? bus.req_rw[g] : 1'b0;
    e_ready = (e_valid && bus.MRA_ready) ? (req_vec_t'(1) << g) : '0;
    e_cnt   = CNT_W'(tags.size());
    check("mra_req_valid", bus.MRA_req_valid === e_valid, $sformatf("%0b", bus.MRA_req_valid),
          $sformatf("%0b", e_valid));
    check("mra_req_addr", bus.MRA_req_addr === e_addr, $sformatf("%0h", bus.MRA_req_addr),
          $sformatf("%0h", e_addr));
    check("mra_rw", bus.MRA_rw === e_rw, $sformatf("%0b", bus.MRA_rw), $sformatf("%0b", e_rw));
    check("req_ready", bus.req_ready === e_ready, $sformatf("%b", bus.req_ready),
          $sformatf("%b", e_ready));
    check("rsp_valid", bus.rsp_valid === m_rsp_valid, $sformatf("%b", bus.rsp_valid),
          $sformatf("%b", m_rsp_valid));
    check("rsp_data", bus.rsp_data === m_rsp_data, $sformatf("%0h", bus.rsp_data),
          $sformatf("%0h", m_rsp_data));
    check("outst_cnt", bus.outst_cnt === e_cnt, $sformatf("%0d", bus.outst_cnt),
          $sformatf("%0d", e_cnt));
    check("err_unexp_rsp", bus.err_unexp_rsp === m_err, $sformatf("%0b", bus.err_unexp_rsp),
          $sformatf("%0b", m_err));
    // Advance to the state after the coming clock edge
    if (e_valid && bus.MRA_ready) begin
      m_ptr  = (g + 1) % int'(NUM_REQ);
      m_lock = 1'b0;
    end else if (e_valid) begin
      m_lock     = 1'b1;
      m_lock_idx = g;
    end
    m_rsp_valid = '0;
    if (bus.MRA_rsp_valid) begin
      if (tags.size() > 0) m_rsp_valid = req_vec_t'(1) << tags.pop_front();
      else m_err = 1'b1;
    end
    if (e_valid && bus.MRA_ready && !e_rw) tags.push_back(g);
    m_rsp_data = bus.MRA_rsp_data;
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (chk_en) model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [DATA_WIDTH-1:0] act,
                     input logic [DATA_WIDTH-1:0] exp);
    check(name, act === exp, $sformatf("%0h", act), $sformatf("%0h", exp));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_zero"},
          bus.MRA_req_valid === 1'b0 && bus.MRA_req_addr === '0 && bus.MRA_rw === 1'b0 &&
          bus.req_ready === '0 && bus.rsp_valid === '0 && bus.rsp_data === '0 &&
          bus.outst_cnt === '0 && bus.err_unexp_rsp === 1'b0,
          $sformatf("v%0b a%0h r%b rv%b c%0d e%0b", bus.MRA_req_valid, bus.MRA_req_addr,
                    bus.req_ready, bus.rsp_valid, bus.outst_cnt, bus.err_unexp_rsp),
          "all zero");
  endtask

  task automatic set_req(input int i, input logic rw, input logic [ADDR_WIDTH-1:0] a);
    bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    bus.req_rw[i] = rw;
  endtask

  task automatic run_random(input int cycles, input int rsp_pct, input int rdy_pct);
    req_vec_t acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = bus.req_ready;
      if (bus.MRA_req_valid && bus.MRA_ready && !bus.MRA_rw) pend++;
      if (bus.MRA_rsp_valid && pend > 0) pend--;
      step();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (bus.req_valid[i] && acc[i]) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i] && $urandom_range(99) < 50) begin
          set_req(i, 1'($urandom_range(1)), {$urandom(), $urandom()});
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.MRA_ready     = ($urandom_range(99) < rdy_pct);
      bus.MRA_rsp_valid = (pend > 0) && ($urandom_range(99) < rsp_pct);
      bus.MRA_rsp_data  = rand_data();
    end
  endtask

  int                    exp_g[6] = '{0, 1, 2, 0, 1, 2};
  int                    gi;
  logic [DATA_WIDTH-1:0] d0, d1, d2, d3;

  initial begin
    bus.req_addr      = '0;
    bus.req_rw        = '0;
    bus.req_valid     = '0;
    bus.MRA_ready     = 1'b0;
    bus.MRA_rsp_data  = '0;
    bus.MRA_rsp_valid = 1'b0;
    #2;
    chk_zero("reset");
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Round-robin over three continuous writers
    step();
    for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 1'b1, 64'(32'h100 * (i + 1)));
    bus.req_valid = '1;
    bus.MRA_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      gi = -1;
      for (int i = 0; i < int'(NUM_REQ); i++) if (bus.req_ready[i]) gi = i;
      check("rr_grant", gi == exp_g[k], $sformatf("%0d", gi), $sformatf("%0d", exp_g[k]));
      step();
    end
    bus.req_valid = '0;
    @(negedge clk);
    lit("writes_outst", 64'(bus.outst_cnt), 64'd0);

    // Single read from requester 1
    step();
    set_req(1, 1'b0, 64'h1000);
    bus.req_valid = 3'b010;
    @(negedge clk);
    lit("t1_addr", bus.MRA_req_addr, 64'h1000);
    lit("t1_ready", 64'(bus.req_ready), 64'b010);
    step();
    bus.req_valid     = '0;
    d0                = rand_data();
    bus.MRA_rsp_data  = d0;
    bus.MRA_rsp_valid = 1'b1;
    step();
    bus.MRA_rsp_valid = 1'b0;
    @(negedge clk);
    lit("t1_rsp_valid", 64'(bus.rsp_valid), 64'b010);
    lit("t1_rsp_data", bus.rsp_data, d0);

    // Stall with lock on requester 2 while requester 0 arrives
    step();
    bus.MRA_ready = 1'b0;
    set_req(2, 1'b1, 64'hABC0);
    bus.req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lit("t3_stall_addr", bus.MRA_req_addr, 64'hABC0);
      lit("t3_stall_ready", 64'(bus.req_ready), 64'd0);
      step();
      set_req(0, 1'b1, 64'h55);
      bus.req_valid = 3'b101;
    end
    bus.MRA_ready = 1'b1;
    @(negedge clk);
    lit("t3_release", 64'(bus.req_ready), 64'b100);
    step();
    bus.req_valid = 3'b001;
    @(negedge clk);
    lit("t3_next", 64'(bus.req_ready), 64'b001);
    step();
    bus.req_valid = '0;

    // Fill the tag FIFO with reads, then confirm writes bypass and reads block
    step();
    bus.req_valid = 3'b001;
    for (int k = 0; k < int'(MAX_OUTST); k++) begin
      set_req(0, 1'b0, 64'(k * 64));
      @(negedge clk);
      lit("t4_fill", 64'(bus.req_ready), 64'b001);
      step();
    end
    set_req(0, 1'b0, 64'h9000);
    set_req(1, 1'b1, 64'h7000);
    bus.req_valid = 3'b011;
    @(negedge clk);
    lit("t4_full_cnt", 64'(bus.outst_cnt), 64'(MAX_OUTST));
    lit("t4_write_flows", 64'(bus.req_ready), 64'b010);
    step();
    bus.req_valid = 3'b001;
    @(negedge clk);
    lit("t4_read_blocked", 64'(bus.MRA_req_valid), 64'd0);
    step();
    bus.MRA_rsp_valid = 1'b1;
    bus.MRA_rsp_data  = rand_data();
    @(negedge clk);
    lit("t4_no_comb_unblock", 64'(bus.req_ready), 64'd0);
    step();
    bus.MRA_rsp_valid = 1'b0;
    @(negedge clk);
    lit("t4_unblocked", 64'(bus.req_ready), 64'b001);
    lit("t4_cnt_after_pop", 64'(bus.outst_cnt), 64'(MAX_OUTST - 1));
    step();
    bus.req_valid     = '0;
    bus.MRA_rsp_valid = 1'b1;
    for (int k = 0; k < int'(MAX_OUTST); k++) begin
      bus.MRA_rsp_data = rand_data();
      step();
    end
    bus.MRA_rsp_valid = 1'b0;
    step();
    @(negedge clk);
    lit("t4_drained", 64'(bus.outst_cnt), 64'd0);

    // Interleaved reads 0,2,1 and in-order responses
    step();
    d0 = rand_data();
    d1 = rand_data();
    d2 = rand_data();
    d3 = rand_data();
    set_req(0, 1'b0, 64'h10);
    bus.req_valid = 3'b001;
    step();
    set_req(2, 1'b0, 64'h20);
    bus.req_valid = 3'b100;
    step();
    set_req(1, 1'b0, 64'h30);
    bus.req_valid = 3'b010;
    step();
    set_req(0, 1'b0, 64'h40);
    bus.req_valid     = 3'b001;
    bus.MRA_rsp_valid = 1'b1;
    bus.MRA_rsp_data  = d0;
    step();
    bus.req_valid    = '0;
    bus.MRA_rsp_data = d1;
    @(negedge clk);
    lit("t5_push_pop_cnt", 64'(bus.outst_cnt), 64'd3);
    lit("t5_rsp0", 64'(bus.rsp_valid), 64'b001);
    lit("t5_data0", bus.rsp_data, d0);
    step();
    bus.MRA_rsp_data = d2;
    @(negedge clk);
    lit("t5_rsp1", 64'(bus.rsp_valid), 64'b100);
    lit("t5_data1", bus.rsp_data, d1);
    step();
    bus.MRA_rsp_data = d3;
    @(negedge clk);
    lit("t5_rsp2", 64'(bus.rsp_valid), 64'b010);
    lit("t5_data2", bus.rsp_data, d2);
    step();
    bus.MRA_rsp_valid = 1'b0;
    @(negedge clk);
    lit("t5_rsp3", 64'(bus.rsp_valid), 64'b001);

    // Random traffic, FIFO-filling then free-flowing
    pend = 0;
    run_random(3000, 15, 70);

    // Asynchronous reset mid-traffic
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    chk_zero("midreset");
    bus.req_valid     = '0;
    bus.MRA_rsp_valid = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    pend   = 0;

    // Response with nothing outstanding
    step();
    bus.MRA_rsp_valid = 1'b1;
    bus.MRA_rsp_data  = rand_data();
    step();
    bus.MRA_rsp_valid = 1'b0;
    @(negedge clk);
    lit("t6_err", 64'(bus.err_unexp_rsp), 64'd1);
    lit("t6_rsp_dropped", 64'(bus.rsp_valid), 64'd0);

    run_random(1500, 60, 50);
    @(negedge clk);
    lit("t6_err_sticky", 64'(bus.err_unexp_rsp), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
